// File: rtl/memory_responder_if.sv
// Request/response bundle between the CPU address path and the memory responder.
// The master side drives the request fields and the slave side drives the completion fields.
interface memory_responder_if;
  logic [31:0] in_mem_address;
  logic [31:0] in_wdata;
  logic        in_req;
  logic        in_write;
  logic        in_byte;
  logic [31:0] out_rdata;
  logic        out_ready;
  logic        out_abort;
  logic        out_busy;

  modport master (
    output in_mem_address, in_wdata, in_req, in_write, in_byte,
    input  out_rdata, out_ready, out_abort, out_busy
  );

  modport slave (
    input  in_mem_address, in_wdata, in_req, in_write, in_byte,
    output out_rdata, out_ready, out_abort, out_busy
  );
endinterface

// File: rtl/memory_responder.sv
// Memory-side responder: captures one request, waits WAIT_STATES cycles, then
// performs a word or byte access on internal RAM and pulses ready (plus abort if out of range).
//
// state  | meaning
// S_IDLE | waiting for in_req; captures the request when it arrives
// S_BUSY | wait-state down-counter running; leaves when the counter reaches 0
// S_DONE | out_ready pulse; a pending write commits on the edge that ends this state
module memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input logic          clk,
  input logic          rst,
  memory_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      wait_cnt, wait_cnt_nxt;
  logic            capture;

  logic [AW-1:0]   idx_q;
  logic [1:0]      lane_q;
  logic [31:0]     wdata_q;
  logic            write_q;
  logic            byte_q;
  logic            abort_q;

  logic [31:0]     ram [DEPTH_WORDS];
  logic [31:0]     rd_q;
  logic [AW-1:0]   in_idx;
  logic [AW-1:0]   rd_idx;
  logic [7:0]      rd_lane;

  assign in_idx = bus.in_mem_address[AW+1:2];

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    capture      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.in_req) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt    = S_BUSY;
            wait_cnt_nxt = WS_LOAD;
          end
        end
      end
      S_BUSY: begin
        if (wait_cnt == 4'd0) state_nxt = S_DONE;
        else                  wait_cnt_nxt = wait_cnt - 4'd1;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Only captured copies are used after acceptance, so later input changes are harmless.
  always_ff @(posedge clk) begin
    if (capture) begin
      idx_q   <= in_idx;
      lane_q  <= bus.in_mem_address[1:0];
      wdata_q <= bus.in_wdata;
      write_q <= bus.in_write;
      byte_q  <= bus.in_byte;
      abort_q <= (bus.in_mem_address[31:2] >= 30'(DEPTH_WORDS));
    end
  end

  // Read the word on the edge entering DONE; with no wait states that is the capture edge.
  assign rd_idx = capture ? in_idx : idx_q;

  always_ff @(posedge clk) begin
    if (state_nxt == S_DONE) rd_q <= ram[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst && state == S_DONE && write_q && !abort_q) begin
      if (byte_q) ram[idx_q][{lane_q, 3'b000} +: 8] <= wdata_q[7:0];
      else        ram[idx_q] <= wdata_q;
    end
  end

  assign rd_lane = rd_q[{lane_q, 3'b000} +: 8];

  always_comb begin
    bus.out_rdata = 32'd0;
    if (state == S_DONE && !write_q && !abort_q)
      bus.out_rdata = byte_q ? {24'd0, rd_lane} : rd_q;
  end

  assign bus.out_ready = (state == S_DONE);
  assign bus.out_abort = (state == S_DONE) && abort_q;
  assign bus.out_busy  = (state != S_IDLE);
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: one instance with two wait states and one with none.
// Each scenario task drives its own vectors and compares against hand-computed values.
module tb_memory_responder;
  logic clk;
  logic rst0, rst1;
  int   total = 0;
  int   bad   = 0;

  memory_responder_if if0 ();
  memory_responder_if if1 ();

  memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut0 (.clk(clk), .rst(rst0), .bus(if0.slave));
  memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic access0(input logic [31:0] addr, input logic [31:0] wd, input logic wr, input logic bt,
                         output int lat, output logic [31:0] rd, output logic ab);
    lat = -1; rd = '0; ab = 1'b0;
    @(negedge clk);
    if0.in_mem_address = addr; if0.in_wdata = wd; if0.in_write = wr; if0.in_byte = bt; if0.in_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if0.in_req = 1'b0;
      if (if0.out_ready) begin lat = i; rd = if0.out_rdata; ab = if0.out_abort; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic access1(input logic [31:0] addr, input logic [31:0] wd, input logic wr, input logic bt,
                         output int lat, output logic [31:0] rd, output logic ab);
    lat = -1; rd = '0; ab = 1'b0;
    @(negedge clk);
    if1.in_mem_address = addr; if1.in_wdata = wd; if1.in_write = wr; if1.in_byte = bt; if1.in_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if1.in_req = 1'b0;
      if (if1.out_ready) begin lat = i; rd = if1.out_rdata; ab = if1.out_abort; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (if0.out_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", if0.out_ready); end
    total++; if (if0.out_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", if0.out_busy); end
    total++; if (if0.out_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", if0.out_rdata); end
    total++; if (if0.out_abort !== 1'b0) begin bad++; $display("FAIL reset_abort got=%b exp=0", if0.out_abort); end
    total++; if (if1.out_busy !== 1'b0) begin bad++; $display("FAIL reset_busy_ws0 got=%b exp=0", if1.out_busy); end
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic ab;
    access0(32'h10, 32'hDEADBEEF, 1'b1, 1'b0, lat, rd, ab);
    total++; if (lat !== 3) begin bad++; $display("FAIL word_wr_latency got=%0d exp=3", lat); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL word_wr_rdata got=%h exp=0", rd); end
    access0(32'h10, 32'h0, 1'b0, 1'b0, lat, rd, ab);
    total++; if (lat !== 3) begin bad++; $display("FAIL word_rd_latency got=%0d exp=3", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_rd_data got=%h exp=deadbeef", rd); end
    total++; if (ab !== 1'b0) begin bad++; $display("FAIL word_rd_abort got=%b exp=0", ab); end
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; logic ab;
    access0(32'h10, 32'h11223344, 1'b1, 1'b0, lat, rd, ab);
    access0(32'h13, 32'hFFFFFFAA, 1'b1, 1'b1, lat, rd, ab);
    total++; if (lat !== 3) begin bad++; $display("FAIL byte_wr_latency got=%0d exp=3", lat); end
    access0(32'h10, 32'h0, 1'b0, 1'b0, lat, rd, ab);
    total++; if (rd !== 32'hAA223344) begin bad++; $display("FAIL byte_merge got=%h exp=aa223344", rd); end
    access0(32'h12, 32'h0, 1'b0, 1'b1, lat, rd, ab);
    total++; if (rd !== 32'h00000022) begin bad++; $display("FAIL byte_rd_lane2 got=%h exp=00000022", rd); end
    access0(32'h13, 32'h0, 1'b0, 1'b1, lat, rd, ab);
    total++; if (rd !== 32'h000000AA) begin bad++; $display("FAIL byte_rd_lane3 got=%h exp=000000aa", rd); end
    access0(32'h10, 32'h0, 1'b0, 1'b1, lat, rd, ab);
    total++; if (rd !== 32'h00000044) begin bad++; $display("FAIL byte_rd_lane0 got=%h exp=00000044", rd); end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd; logic ab;
    access0(32'h0, 32'hCAFEF00D, 1'b1, 1'b0, lat, rd, ab);
    access0(32'h1000, 32'h0, 1'b0, 1'b0, lat, rd, ab);
    total++; if (lat !== 3) begin bad++; $display("FAIL abort_latency got=%0d exp=3", lat); end
    total++; if (ab !== 1'b1) begin bad++; $display("FAIL abort_flag got=%b exp=1", ab); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL abort_rdata got=%h exp=0", rd); end
    access0(32'h1000, 32'h99999999, 1'b1, 1'b0, lat, rd, ab);
    total++; if (ab !== 1'b1) begin bad++; $display("FAIL abort_wr_flag got=%b exp=1", ab); end
    access0(32'h0, 32'h0, 1'b0, 1'b0, lat, rd, ab);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL abort_word0 got=%h exp=cafef00d", rd); end
    access0(32'h10, 32'h0, 1'b0, 1'b0, lat, rd, ab);
    total++; if (rd !== 32'hAA223344) begin bad++; $display("FAIL abort_word4 got=%h exp=aa223344", rd); end
    access0(32'hFFC, 32'h7777AAAA, 1'b1, 1'b0, lat, rd, ab);
    access0(32'hFFC, 32'h0, 1'b0, 1'b0, lat, rd, ab);
    total++; if (ab !== 1'b0) begin bad++; $display("FAIL last_word_abort got=%b exp=0", ab); end
    total++; if (rd !== 32'h7777AAAA) begin bad++; $display("FAIL last_word_data got=%h exp=7777aaaa", rd); end
  endtask

  task automatic test_hold_req();
    int lat; logic [31:0] rd; logic ab;
    logic [11:0] ready_pat, busy_pat;
    int wait_cnt;
    ready_pat = '0; busy_pat = '0;
    @(negedge clk);
    if0.in_mem_address = 32'h10; if0.in_write = 1'b0; if0.in_byte = 1'b0; if0.in_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      ready_pat[i] = if0.out_ready;
      busy_pat[i]  = if0.out_busy;
    end
    if0.in_req = 1'b0;
    total++; if (ready_pat !== 12'h444) begin bad++; $display("FAIL hold_ready_pattern got=%h exp=444", ready_pat); end
    total++; if (busy_pat !== 12'h777) begin bad++; $display("FAIL hold_busy_pattern got=%h exp=777", busy_pat); end

    access0(32'h34, 32'h0BADCAFE, 1'b1, 1'b0, lat, rd, ab);
    @(negedge clk);
    if0.in_mem_address = 32'h30; if0.in_wdata = 32'h12345678; if0.in_write = 1'b1; if0.in_byte = 1'b0; if0.in_req = 1'b1;
    @(posedge clk); #1;
    if0.in_req = 1'b0;
    if0.in_mem_address = 32'h34; if0.in_wdata = 32'hFFFFFFFF; if0.in_byte = 1'b1;
    wait_cnt = 0;
    while (!if0.out_ready && wait_cnt < 20) begin @(posedge clk); #1; wait_cnt++; end
    total++; if (wait_cnt !== 2) begin bad++; $display("FAIL capture_latency got=%0d exp=2", wait_cnt); end
    @(posedge clk); #1;
    access0(32'h30, 32'h0, 1'b0, 1'b0, lat, rd, ab);
    total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL capture_wdata got=%h exp=12345678", rd); end
    access0(32'h34, 32'h0, 1'b0, 1'b0, lat, rd, ab);
    total++; if (rd !== 32'h0BADCAFE) begin bad++; $display("FAIL capture_addr got=%h exp=0badcafe", rd); end
  endtask

  task automatic test_reset_busy();
    int lat; logic [31:0] rd; logic ab;
    int readies;
    access0(32'h20, 32'h11111111, 1'b1, 1'b0, lat, rd, ab);
    @(negedge clk);
    if0.in_mem_address = 32'h20; if0.in_wdata = 32'h55; if0.in_write = 1'b1; if0.in_byte = 1'b0; if0.in_req = 1'b1;
    @(posedge clk); #1;
    if0.in_req = 1'b0;
    total++; if (if0.out_busy !== 1'b1) begin bad++; $display("FAIL rst_busy_pre got=%b exp=1", if0.out_busy); end
    rst0 = 1'b1;
    @(posedge clk); #1;
    total++; if (if0.out_busy !== 1'b0) begin bad++; $display("FAIL rst_busy_post got=%b exp=0", if0.out_busy); end
    total++; if (if0.out_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_post got=%b exp=0", if0.out_ready); end
    rst0 = 1'b0;
    readies = 0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (if0.out_ready) readies++; end
    total++; if (readies !== 0) begin bad++; $display("FAIL rst_no_ready got=%0d exp=0", readies); end
    access0(32'h20, 32'h0, 1'b0, 1'b0, lat, rd, ab);
    total++; if (rd !== 32'h11111111) begin bad++; $display("FAIL rst_write_dropped got=%h exp=11111111", rd); end

    access1(32'h20, 32'h11111111, 1'b1, 1'b0, lat, rd, ab);
    total++; if (lat !== 1) begin bad++; $display("FAIL ws0_latency got=%0d exp=1", lat); end
    @(negedge clk);
    if1.in_mem_address = 32'h20; if1.in_wdata = 32'h55; if1.in_write = 1'b1; if1.in_byte = 1'b0; if1.in_req = 1'b1;
    @(posedge clk); #1;
    if1.in_req = 1'b0;
    total++; if (if1.out_ready !== 1'b1) begin bad++; $display("FAIL ws0_done got=%b exp=1", if1.out_ready); end
    rst1 = 1'b1;
    @(posedge clk); #1;
    total++; if (if1.out_busy !== 1'b0) begin bad++; $display("FAIL ws0_rst_busy got=%b exp=0", if1.out_busy); end
    total++; if (if1.out_ready !== 1'b0) begin bad++; $display("FAIL ws0_rst_ready got=%b exp=0", if1.out_ready); end
    rst1 = 1'b0;
    access1(32'h20, 32'h0, 1'b0, 1'b0, lat, rd, ab);
    total++; if (lat !== 1) begin bad++; $display("FAIL ws0_rd_latency got=%0d exp=1", lat); end
    total++; if (rd !== 32'h11111111) begin bad++; $display("FAIL ws0_write_dropped got=%h exp=11111111", rd); end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    if0.in_mem_address = '0; if0.in_wdata = '0; if0.in_req = 1'b0; if0.in_write = 1'b0; if0.in_byte = 1'b0;
    if1.in_mem_address = '0; if1.in_wdata = '0; if1.in_req = 1'b0; if1.in_write = 1'b0; if1.in_byte = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_abort();
    test_hold_req();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
